tt_um_pwm_bank: RTL and testbench

TT_UM_PWM_BANK -- requirements
Module: tt_um_pwm_bank

---
 rtl/tt_pwm_pkg.sv | 19 +
 rtl/tt_pwm_channel.sv | 37 +++
 rtl/tt_um_pwm_bank.sv | 121 ++++++++++++
 tb/tb_tt_um_pwm_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pwm_pkg.sv
// Shared definitions for the PWM bank: register map, CTRL layout and the
// address type used by the write decoder.
package tt_pwm_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t CTRL_ADDR    = 3'd7;
  localparam int        CTRL_EN_BIT  = 0;
  localparam int        CTRL_PRE_LSB = 1;
  localparam int        PRESCALE_W   = 4;
  localparam int        CTRL_INV_BIT = 5;

  typedef struct packed {
    logic                  inv;
    logic [PRESCALE_W-1:0] prescale;
    logic                  en;
  } ctrl_t;

endpackage

// File: rtl/tt_pwm_channel.sv
// One PWM channel: shadow duty written by the host, active duty used for the
// compare, and a registered (optionally inverted) output.
module tt_pwm_channel
  import tt_pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  input  logic             track,
  input  logic             run,
  input  logic             inv,
  input  logic [CNT_W-1:0] count,
  output logic             pwm
);

  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] active;

  // Active picks up the pre-write shadow on a wrap, so a write landing on the
  // wrap edge only shows up one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (track || load) active <= shadow;
      pwm <= run & ((active > count) ^ inv);
    end
  end

endmodule

// File: rtl/tt_um_pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one prescaled counter, programmed
// through a strobed register write port on ui_in/uio_in.
module tt_um_pwm_bank
  import tt_pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  strobe_s1;
  logic                  strobe_s2;
  logic                  strobe_d;
  logic                  strobe_rise;
  logic                  commit;
  logic                  ctrl_wr;
  reg_addr_t             wr_addr;
  ctrl_t                 ctrl;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [CNT_W-1:0]      count;
  logic                  advance;
  logic                  wrap;
  logic                  wrap_q;
  logic [NUM_CH-1:0]     pwm;
  logic                  unused_bits;

  assign unused_bits = ^{ui_in[6:3], uio_in};

  // The strobe comes from an unrelated domain, so it is double-flopped
  // before the edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
      strobe_d  <= 1'b0;
    end else begin
      strobe_s1 <= ui_in[7];
      strobe_s2 <= strobe_s1;
      strobe_d  <= strobe_s2;
    end
  end

  assign strobe_rise = strobe_s2 & ~strobe_d;
  assign wr_addr     = ui_in[2:0];
  assign commit      = strobe_rise & ena;
  assign ctrl_wr     = commit && (wr_addr == CTRL_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (ctrl_wr) begin
      ctrl.en       <= uio_in[CTRL_EN_BIT];
      ctrl.prescale <= uio_in[CTRL_PRE_LSB +: PRESCALE_W];
      ctrl.inv      <= uio_in[CTRL_INV_BIT];
    end
  end

  assign advance = ctrl.en & ena & ~ctrl_wr & (presc_cnt == ctrl.prescale);
  assign wrap    = advance & (count == CNT_MAX);

  // A CTRL write restarts the prescale phase but leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      count     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= wrap;
      if (!ctrl.en) begin
        presc_cnt <= '0;
        count     <= '0;
      end else if (ctrl_wr) begin
        presc_cnt <= '0;
      end else if (ena) begin
        if (presc_cnt == ctrl.prescale) begin
          presc_cnt <= '0;
          count     <= count + 1'b1;
        end else begin
          presc_cnt <= presc_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tt_pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (commit && (wr_addr == reg_addr_t'(i))),
      .wr_data (uio_in[CNT_W-1:0]),
      .load    (wrap),
      .track   (~ctrl.en),
      .run     (ctrl.en),
      .inv     (ctrl.inv),
      .count   (count),
      .pwm     (pwm[i])
    );
  end

  always_comb begin
    uo_out = 8'h00;
    if (ena) begin
      uo_out[NUM_CH-1:0] = pwm;
      uo_out[7]          = wrap_q;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_pwm_bank.sv
// Bench for tt_um_pwm_bank: a per-cycle behavioural model checked on every
// negedge, plus directed period measurements with hand-computed counts.
module tb_tt_um_pwm_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  tt_um_pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Model: count = base + (clocks run since last restart)/(PRESCALE+1).
  int m_en = 0, m_pre = 0, m_inv = 0, m_base = 0, m_ticks = 0, m_edges = 0;
  int m_wrap = 0;
  int commit_at = -1;
  int m_shadow[NUM_CH];
  int m_active[NUM_CH];
  int m_pwm[NUM_CH];
  logic [7:0] exp_uo;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelCount();
    return (m_base + m_ticks / (m_pre + 1)) % CNT_MOD;
  endfunction

  task automatic modelReset();
    m_en = 0; m_pre = 0; m_inv = 0; m_base = 0; m_ticks = 0; m_wrap = 0;
    commit_at = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = 0; m_active[i] = 0; m_pwm[i] = 0;
    end
  endtask

  task automatic modelStep();
    int cnt, a, d;
    bit ctrl_wr, sh_wr, adv, wrap_now;
    m_edges++;
    cnt = modelCount();
    a = int'(ui_in[2:0]);
    d = int'(uio_in);
    ctrl_wr = 0;
    sh_wr = 0;
    if (m_edges == commit_at && ena) begin
      if (a == 7) ctrl_wr = 1;
      else if (a < NUM_CH) sh_wr = 1;
    end
    adv = (m_en != 0) && ena && !ctrl_wr && ((m_ticks + 1) % (m_pre + 1) == 0);
    wrap_now = adv && (cnt == CNT_MOD - 1);
    for (int i = 0; i < NUM_CH; i++) begin
      m_pwm[i] = (m_en != 0) ? (int'(m_active[i] > cnt) ^ m_inv) : 0;
      if (m_en == 0 || wrap_now) m_active[i] = m_shadow[i];
    end
    if (sh_wr) m_shadow[a] = d % CNT_MOD;
    if (m_en == 0) begin
      m_base = 0; m_ticks = 0;
    end else if (ctrl_wr) begin
      m_base = cnt; m_ticks = 0;
    end else if (ena) begin
      m_ticks++;
    end
    if (ctrl_wr) begin
      m_en  = d & 1;
      m_pre = (d >> 1) & 15;
      m_inv = (d >> 5) & 1;
    end
    m_wrap = int'(wrap_now);
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_on) begin
        exp_uo = 8'h00;
        if (ena) begin
          for (int i = 0; i < NUM_CH; i++) exp_uo[i] = (m_pwm[i] != 0);
          exp_uo[7] = (m_wrap != 0);
        end
        checkOutput("uo_out_model", uo_out, exp_uo);
        checkOutput("uio_out_zero", uio_out, 8'h00);
        checkOutput("uio_oe_zero", uio_oe, 8'h00);
      end
    end
  end

  // Register write: strobe high until past the commit edge, then low long
  // enough for the edge detector to re-arm.
  task automatic applyStimulus(input int addr, input int data);
    logic [2:0] a3;
    logic [7:0] d8;
    a3 = addr[2:0];
    d8 = data[7:0];
    @(negedge clk);
    ui_in  = {1'b1, 4'b0000, a3};
    uio_in = d8;
    commit_at = m_edges + 3;
    repeat (3) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic waitWrap(input int budget, output int waited);
    waited = 0;
    while (waited < budget) begin
      @(negedge clk);
      waited++;
      if (uo_out[7]) return;
    end
    checkOutput("wrap_wait_timeout", uo_out[7], 1);
  endtask

  task automatic measurePeriod(input int ch, input int len, output int highs, output int wraps);
    highs = 0;
    wraps = 0;
    repeat (len) begin
      @(negedge clk);
      if (uo_out[ch]) highs++;
      if (uo_out[7]) wraps++;
    end
  endtask

  initial begin
    int h, w, h2, w2, k;
    repeat (3) @(negedge clk);
    check_on = 1'b1;
    checkOutput("reset_uo_out", uo_out, 8'h00);
    rst_n = 1'b1;

    applyStimulus(0, 'h40);
    applyStimulus(7, 'h01);
    waitWrap(600, k);
    checkOutput("first_wrap_latency", k, 253);
    measurePeriod(0, 256, h, w);
    checkOutput("duty40_high", h, 64);
    checkOutput("duty40_wraps", w, 1);

    fork
      begin repeat (40) @(negedge clk); applyStimulus(0, 'hC0); end
      measurePeriod(0, 256, h, w);
    join
    checkOutput("midwrite_current", h, 64);
    measurePeriod(0, 256, h, w);
    checkOutput("midwrite_next", h, 192);

    fork
      begin repeat (252) @(negedge clk); applyStimulus(0, 'h10); end
      begin measurePeriod(0, 256, h, w); measurePeriod(0, 256, h2, w2); end
    join
    checkOutput("onwrap_before", h, 192);
    checkOutput("onwrap_deferred", h2, 192);
    measurePeriod(0, 256, h, w);
    checkOutput("onwrap_applied", h, 16);

    applyStimulus(7, 'h00);
    applyStimulus(0, 'h00);
    applyStimulus(1, 'hFF);
    applyStimulus(7, 'h21);
    waitWrap(600, k);
    measurePeriod(0, 256, h, w);
    checkOutput("inv_duty00_high", h, 256);
    measurePeriod(1, 256, h, w);
    checkOutput("inv_dutyFF_high", h, 1);

    applyStimulus(7, 'h00);
    applyStimulus(1, 'h80);
    applyStimulus(7, 'h07);
    waitWrap(1500, k);
    checkOutput("prescale_first_wrap", k, 1021);
    measurePeriod(1, 1024, h, w);
    checkOutput("prescale_high", h, 512);
    checkOutput("prescale_wraps", w, 1);

    applyStimulus(5, 'h00);
    waitWrap(1500, k);
    measurePeriod(1, 1024, h, w);
    checkOutput("addr5_ignored", h, 512);

    repeat (100) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    checkOutput("ena0_uo_out", uo_out, 8'h00);
    repeat (49) @(negedge clk);
    ena = 1'b1;
    waitWrap(1500, k);
    checkOutput("ena_resume_count", k, 924);

    repeat (300) @(negedge clk);
    checkOutput("pre_reset_ch1", uo_out[1], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_uo", uo_out, 8'h00);
    checkOutput("async_reset_uio_out", uio_out, 8'h00);
    checkOutput("async_reset_uio_oe", uio_oe, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measurePeriod(1, 300, h, w);
    checkOutput("post_reset_high", h, 0);
    checkOutput("post_reset_wraps", w, 0);
    applyStimulus(0, 'h40);
    applyStimulus(7, 'h01);
    waitWrap(600, k);
    checkOutput("post_reset_first_wrap", k, 253);
    measurePeriod(0, 256, h, w);
    checkOutput("post_reset_duty40", h, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
